lua_imem_responder: RTL and testbench

//  Instruction-memory responder: serves the fetch stage's PC requests with Lua

---
 rtl/lua_isa_pkg.sv | 24 ++
 rtl/lua_resp_fifo.sv | 56 +++++
 rtl/lua_imem_responder.sv | 126 ++++++++++++
 tb/tb_lua_imem_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lua_isa_pkg.sv
// Lua ISA constants and payload types shared by the fetch, decode and imem blocks.
package lua_isa_pkg;

  localparam int unsigned INST_W     = 32;
  localparam int unsigned OPCODE_W   = 8;
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned OPCODE_MSB = OPCODE_LSB + OPCODE_W - 1;
  localparam int unsigned ADDR_W     = 32;

  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0000;

  // Instruction memory response payload: error flag above the instruction word.
  typedef struct packed {
    logic              err;
    logic [INST_W-1:0] inst;
  } imem_rsp_t;

  localparam int unsigned RSP_W = 1 + INST_W;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INST_W-1:0] inst);
    return inst[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/lua_resp_fifo.sv
// First-word-fall-through response buffer; head entry is visible whenever count != 0.
module lua_resp_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             n_reset,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 pop_data,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_en;
  logic             pop_en;

  // A pop against an empty buffer is dropped, even when a push lands the same edge.
  always_comb begin
    push_en = push & (count != CNT_W'(DEPTH));
    pop_en  = pop & (count != '0);
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/lua_imem_responder.sv
// Instruction memory responder: program array, fixed-latency read pipeline,
// credit-based request flow control and an in-order response buffer.
module lua_imem_responder
  import lua_isa_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [INST_W-1:0]     rsp_inst,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [INST_W-1:0]     ld_data
);

  localparam int unsigned MEM_DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);

  logic [INST_W-1:0] mem [MEM_DEPTH];
  imem_rsp_t         rd_rsp;
  imem_rsp_t         push_data;
  imem_rsp_t         fifo_head;
  logic              push;
  logic              accept;
  logic              pop;
  logic              addr_err;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  fifo_count;
  logic              rdy_q;

  // Program image; intentionally not reset so contents survive n_reset.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Read and range check in the accept cycle; upper address bits are never wrapped.
  always_comb begin
    addr_err    = |req_addr[ADDR_W-1:DEPTH_LOG2];
    rd_rsp.err  = addr_err;
    rd_rsp.inst = addr_err ? '0 : mem[req_addr[DEPTH_LOG2-1:0]];
  end

  assign accept = req_valid & req_ready;
  assign pop    = rsp_valid & rsp_ready;

  // Credits cover every slot in the pipeline and buffer, so the buffer cannot overflow.
  always_comb begin
    cnt_nxt = cnt;
    case ({accept, pop})
      2'b10:   cnt_nxt = cnt - CNT_W'(1);
      2'b01:   cnt_nxt = cnt + CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt   <= CNT_W'(FIFO_DEPTH);
      rdy_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      rdy_q <= (cnt_nxt != '0);
    end
  end

  assign req_ready = rdy_q & ~ld_en;

  generate
    if (LATENCY == 1) begin : g_direct
      always_comb begin
        push      = accept;
        push_data = rd_rsp;
      end
    end else begin : g_pipe
      localparam int unsigned STAGES = LATENCY - 1;
      logic [STAGES-1:0] pipe_vld;
      imem_rsp_t         pipe_q [STAGES];

      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          pipe_vld <= '0;
          for (int i = 0; i < int'(STAGES); i++) pipe_q[i] <= '0;
        end else begin
          pipe_vld[0] <= accept;
          pipe_q[0]   <= rd_rsp;
          for (int i = 1; i < int'(STAGES); i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_q[i]   <= pipe_q[i-1];
          end
        end
      end

      always_comb begin
        push      = pipe_vld[STAGES-1];
        push_data = pipe_q[STAGES-1];
      end
    end
  endgenerate

  lua_resp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .n_reset   (n_reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

  assign rsp_valid = (fifo_count != '0);
  assign rsp_inst  = fifo_head.inst;
  assign rsp_err   = fifo_head.err;

endmodule

// File: tb/tb_lua_imem_responder.sv
// Directed and randomized checks of lua_imem_responder at LATENCY 1, 2 and 4.
module tb_lua_imem_responder;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  logic        req_ready_v [3];
  logic        rsp_valid_v [3];
  logic        rsp_err_v   [3];
  logic [31:0] rsp_inst_v  [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lua_imem_responder #(.DEPTH_LOG2(8), .LATENCY(2), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .n_reset(n_reset), .req_valid(req_valid), .req_ready(req_ready_v[0]),
    .req_addr(req_addr), .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready),
    .rsp_inst(rsp_inst_v[0]), .rsp_err(rsp_err_v[0]), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data));

  lua_imem_responder #(.DEPTH_LOG2(8), .LATENCY(1), .FIFO_DEPTH(4)) u_lat1 (
    .clk(clk), .n_reset(n_reset), .req_valid(req_valid), .req_ready(req_ready_v[1]),
    .req_addr(req_addr), .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready),
    .rsp_inst(rsp_inst_v[1]), .rsp_err(rsp_err_v[1]), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data));

  lua_imem_responder #(.DEPTH_LOG2(8), .LATENCY(4), .FIFO_DEPTH(5)) u_lat4 (
    .clk(clk), .n_reset(n_reset), .req_valid(req_valid), .req_ready(req_ready_v[2]),
    .req_addr(req_addr), .rsp_valid(rsp_valid_v[2]), .rsp_ready(rsp_ready),
    .rsp_inst(rsp_inst_v[2]), .rsp_err(rsp_err_v[2]), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  // Reference copy of the program image, written on the same edge as the array.
  logic [31:0] model [256];
  always @(posedge clk) begin
    if (ld_en) model[ld_addr] <= ld_data;
  end

  function automatic logic [32:0] exp_rsp(input logic [31:0] a);
    if (a >= 32'd256) return {1'b1, 32'h0};
    return {1'b0, model[a[7:0]]};
  endfunction

  // Per-instance in-order scoreboard; handshakes are evaluated just before the edge.
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_sb
      localparam int DEP = (g == 2) ? 5 : 4;
      logic [32:0] q [$];
      always @(negedge clk) begin
        if (!n_reset) begin
          q.delete();
        end else begin
          if (rsp_valid_v[g]) begin
            if (q.size() == 0) begin
              check_eq($sformatf("sb%0d_unexpected_rsp", g), 64'd1, 64'd0);
            end else begin
              check_eq($sformatf("sb%0d_rsp", g), {31'd0, rsp_err_v[g], rsp_inst_v[g]}, {31'd0, q[0]});
              if (rsp_ready) void'(q.pop_front());
            end
          end
          if (req_valid && req_ready_v[g]) begin
            q.push_back(exp_rsp(req_addr));
            check_eq($sformatf("sb%0d_credit", g), 64'(q.size() <= DEP), 64'd1);
          end
        end
      end
    end
  endgenerate

  // Responses consumed from the LATENCY=2 instance, for directed sequence checks.
  logic [32:0] got_q [$];
  always @(negedge clk) begin
    if (!n_reset) got_q.delete();
    else if (rsp_valid_v[0] && rsp_ready) got_q.push_back({rsp_err_v[0], rsp_inst_v[0]});
  end

  int t2_inst [8] = '{0, 0, 'h11, 'h22, 'h33, 'h44, 0, 0};

  initial begin
    int acc;
    n_reset   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;

    // Power-on reset values
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", req_ready_v[0], 0);
    check_eq("rst_rsp_valid", rsp_valid_v[0], 0);
    check_eq("rst_rsp_inst", rsp_inst_v[0], 0);
    check_eq("rst_rsp_err", rsp_err_v[0], 0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(negedge clk);
    check_eq("rel_ready_before_edge", req_ready_v[0], 0);
    tick();
    @(negedge clk);
    check_eq("rel_ready_first_edge", req_ready_v[0], 1);
    tick();

    // Program image: 0..3 fixed, 4..15 patterned
    load_word(8'd0, 32'h11);
    load_word(8'd1, 32'h22);
    load_word(8'd2, 32'h33);
    load_word(8'd3, 32'h44);
    for (int i = 4; i < 16; i++) load_word(8'(i), 32'hA000_0000 + 32'(i));

    // Back-to-back fetches, LATENCY=2 timing
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k < 4);
      req_addr  = 32'(k);
      @(negedge clk);
      if (k < 4) check_eq($sformatf("t2_ready_%0d", k), req_ready_v[0], 1);
      check_eq($sformatf("t2_valid_%0d", k), rsp_valid_v[0], 64'(t2_inst[k] != 0));
      if (t2_inst[k] != 0) check_eq($sformatf("t2_inst_%0d", k), rsp_inst_v[0], 64'(t2_inst[k]));
      tick();
    end
    req_valid = 1'b0;

    // Backpressure: exactly four accepts, then drain in order
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    acc = 0;
    req_addr = 32'd4;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req_ready_v[0]) acc++;
      tick();
      req_addr = 32'd4 + 32'(acc);
    end
    req_valid = 1'b0;
    check_eq("bp_accepts", 64'(acc), 64'd4);
    @(negedge clk);
    check_eq("bp_ready_low", req_ready_v[0], 0);
    check_eq("bp_valid_held", rsp_valid_v[0], 1);
    check_eq("bp_inst_held", rsp_inst_v[0], 32'hA000_0004);
    tick();
    got_q.delete();
    rsp_ready = 1'b1;
    repeat (8) tick();
    check_eq("bp_drain_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check_eq($sformatf("bp_drain_%0d", i), 64'(got_q[i]), {31'd0, 1'b0, 32'hA000_0004 + 32'(i)});
    @(negedge clk);
    check_eq("bp_ready_back", req_ready_v[0], 1);
    tick();

    // Out-of-range request between two good ones
    got_q.delete();
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_addr  = (k == 0) ? 32'd1 : (k == 1) ? 32'd256 : 32'd2;
      @(negedge clk);
      check_eq($sformatf("oor_ready_%0d", k), req_ready_v[0], 1);
      tick();
    end
    req_valid = 1'b0;
    repeat (6) tick();
    check_eq("oor_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      check_eq("oor_first", 64'(got_q[0]), {31'd0, 1'b0, 32'h22});
      check_eq("oor_err", 64'(got_q[1]), {31'd0, 1'b1, 32'h0});
      check_eq("oor_last", 64'(got_q[2]), {31'd0, 1'b0, 32'h33});
    end

    // Load collisions: in-flight read keeps old word, blocked request sees new word
    got_q.delete();
    req_valid = 1'b1;
    req_addr  = 32'd6;
    tick();
    req_valid = 1'b0;
    ld_en = 1'b1; ld_addr = 8'd6; ld_data = 32'hBEEF_0006;
    tick();
    ld_addr = 8'd5; ld_data = 32'hBEEF_0005;
    req_valid = 1'b1;
    req_addr  = 32'd5;
    @(negedge clk);
    check_eq("ld_blocks_ready", req_ready_v[0], 0);
    tick();
    ld_en = 1'b0;
    @(negedge clk);
    check_eq("ld_ready_after", req_ready_v[0], 1);
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    check_eq("ld_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check_eq("ld_old_word", 64'(got_q[0]), {31'd0, 1'b0, 32'hA000_0006});
      check_eq("ld_new_word", 64'(got_q[1]), {31'd0, 1'b0, 32'hBEEF_0005});
    end

    // Reset mid-traffic discards in-flight and buffered responses
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_addr  = 32'(k);
      tick();
    end
    req_valid = 1'b0;
    n_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("mid_rst_valid_%0d", k), rsp_valid_v[0], 0);
      check_eq($sformatf("mid_rst_ready_%0d", k), req_ready_v[0], 0);
      tick();
    end
    n_reset = 1'b1;
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check_eq("mid_rel_ready", req_ready_v[0], 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq($sformatf("mid_no_stale_%0d", k),
               {61'd0, rsp_valid_v[0], rsp_valid_v[1], rsp_valid_v[2]}, 64'd0);
      tick();
    end
    got_q.delete();
    req_valid = 1'b1;
    req_addr  = 32'd1;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    check_eq("mid_mem_kept", 64'(got_q.size() == 1 ? got_q[0] : 33'h1_FFFF_FFFF), {31'd0, 1'b0, 32'h22});

    // Randomized traffic across all three latencies
    for (int k = 0; k < 600; k++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = ($urandom_range(0, 7) == 0) ? 32'd256 + 32'($urandom_range(0, 300))
                                              : 32'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 2) != 0);
      ld_en     = ($urandom_range(0, 15) == 0);
      ld_addr   = 8'($urandom_range(0, 15));
      ld_data   = $urandom;
      tick();
    end
    req_valid = 1'b0;
    ld_en     = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) tick();
    check_eq("drain_lat2", 64'(g_sb[0].q.size()), 64'd0);
    check_eq("drain_lat1", 64'(g_sb[1].q.size()), 64'd0);
    check_eq("drain_lat4", 64'(g_sb[2].q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
